// File: rtl/vermibus_pkg.sv
// Shared Vermibus types: arbiter FSM encoding, bus-owner tag and bus widths.
package vermibus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arbiter_state_t;
  typedef enum logic {OWNER_I, OWNER_D} bus_owner_t;

  function automatic arbiter_state_t grant_of(bus_owner_t owner);
    return (owner == OWNER_I) ? GRANT_I : GRANT_D;
  endfunction

  function automatic bus_owner_t other_owner(bus_owner_t owner);
    return (owner == OWNER_I) ? OWNER_D : OWNER_I;
  endfunction

endpackage

// File: rtl/vermibus_if.sv
// Vermibus request/response bundle; request modports drive, response modports answer.
interface Vermibus;
  import vermibus_pkg::*;

  logic              valid;
  logic [ADDR_W-1:0] address;
  logic [STRB_W-1:0] wstrobe;
  logic [DATA_W-1:0] wdata;
  logic              lookahead;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport read_only_request (
    output valid, address, lookahead,
    input  ready, rdata
  );

  modport read_only_response (
    input  valid, address, lookahead,
    output ready, rdata
  );

  modport read_write_request (
    output valid, address, wstrobe, wdata, lookahead,
    input  ready, rdata
  );

  modport read_write_response (
    input  valid, address, wstrobe, wdata, lookahead,
    output ready, rdata
  );

endinterface

// File: rtl/vermibus_arbiter.sv
// Two-to-one Vermibus arbiter: instruction and data requesters share one memory bus,
// grant held until the memory side acknowledges, round-robin or data-priority on contention.
module vermibus_arbiter
  import vermibus_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  Vermibus.read_only_response  ibus,
  Vermibus.read_write_response dbus,
  Vermibus.read_write_request  mbus
);

  arbiter_state_t state;
  arbiter_state_t state_next;
  bus_owner_t     last_grant;
  bus_owner_t     last_grant_next;
  logic           unused_lookahead;

  // Lookahead from the requesters cannot survive an arbitration cycle, so it is dropped.
  assign unused_lookahead = ibus.lookahead ^ dbus.lookahead;

  assign ibus.rdata = mbus.rdata;
  assign dbus.rdata = mbus.rdata;

  function automatic arbiter_state_t arbitrate(logic iv, logic dv, bus_owner_t last);
    arbiter_state_t pick;
    pick = IDLE;
    if (iv && dv)
      pick = (ROUND_ROBIN != 0) ? grant_of(other_owner(last)) : GRANT_D;
    else if (iv)
      pick = GRANT_I;
    else if (dv)
      pick = GRANT_D;
    return pick;
  endfunction

  function automatic arbiter_state_t after_done(bus_owner_t owner, logic iv, logic dv);
    arbiter_state_t pick;
    logic           other_valid;
    other_valid = (owner == OWNER_I) ? dv : iv;
    if (ROUND_ROBIN != 0)
      pick = other_valid ? grant_of(other_owner(owner)) : IDLE;
    else if (dv)
      pick = GRANT_D;
    else if (iv)
      pick = GRANT_I;
    else
      pick = IDLE;
    return pick;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= OWNER_I;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    mbus.valid      = 1'b0;
    mbus.address    = '0;
    mbus.wstrobe    = '0;
    mbus.wdata      = '0;
    mbus.lookahead  = 1'b0;
    ibus.ready      = 1'b0;
    dbus.ready      = 1'b0;

    unique case (state)
      IDLE: begin
        state_next = arbitrate(ibus.valid, dbus.valid, last_grant);
      end

      GRANT_I: begin
        mbus.valid   = ibus.valid;
        mbus.address = ibus.address;
        ibus.ready   = mbus.ready;
        // A requester withdrawing before its ready is an abort, not a transfer.
        if (!ibus.valid) begin
          state_next = IDLE;
        end else if (mbus.ready) begin
          last_grant_next = OWNER_I;
          state_next      = after_done(OWNER_I, ibus.valid, dbus.valid);
        end
      end

      GRANT_D: begin
        mbus.valid   = dbus.valid;
        mbus.address = dbus.address;
        mbus.wstrobe = dbus.wstrobe;
        mbus.wdata   = dbus.wdata;
        dbus.ready   = mbus.ready;
        if (!dbus.valid) begin
          state_next = IDLE;
        end else if (mbus.ready) begin
          last_grant_next = OWNER_D;
          state_next      = after_done(OWNER_D, ibus.valid, dbus.valid);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vermibus_arbiter.sv
// Bench for vermibus_arbiter: round-robin and data-priority instances driven side by side.
module tb_vermibus_arbiter;

  logic clk;
  logic reset_n;

  Vermibus i_rr ();
  Vermibus d_rr ();
  Vermibus m_rr ();
  Vermibus i_fp ();
  Vermibus d_fp ();
  Vermibus m_fp ();

  vermibus_arbiter #(.ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .reset_n(reset_n), .ibus(i_rr), .dbus(d_rr), .mbus(m_rr)
  );

  vermibus_arbiter #(.ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .reset_n(reset_n), .ibus(i_fp), .dbus(d_fp), .mbus(m_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Owner codes for the reference model: 0 = nobody, 1 = instruction, 2 = data.
  int own_rr = 0, last_rr = 1;
  int own_fp = 0, last_fp = 1;

  typedef struct packed {
    logic        mv;
    logic [31:0] ma;
    logic [3:0]  ms;
    logic [31:0] md;
    logic        ir;
    logic        dr;
  } outs_t;

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [3:0]  ds;
    logic [31:0] dw;
    logic        mr;
    logic [31:0] rd;
    outs_t       e;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void model_next(input bit rr, input int own, input int last,
                                     input logic iv, input logic dv, input logic mr,
                                     output int own_n, output int last_n);
    logic owner_valid, other_valid;
    own_n  = own;
    last_n = last;
    if (own == 0) begin
      if (iv && dv)  own_n = rr ? ((last == 1) ? 2 : 1) : 2;
      else if (iv)   own_n = 1;
      else if (dv)   own_n = 2;
    end else begin
      owner_valid = (own == 1) ? iv : dv;
      other_valid = (own == 1) ? dv : iv;
      if (!owner_valid) begin
        own_n = 0;
      end else if (mr) begin
        last_n = own;
        if (rr) own_n = other_valid ? (3 - own) : 0;
        else    own_n = dv ? 2 : (iv ? 1 : 0);
      end
    end
  endfunction

  function automatic outs_t model_out(input int own, input logic iv, input logic [31:0] ia,
                                      input logic dv, input logic [31:0] da,
                                      input logic [3:0] ds, input logic [31:0] dw,
                                      input logic mr);
    outs_t o;
    o = '0;
    if (own == 1) begin
      o.mv = iv; o.ma = ia; o.ir = mr;
    end else if (own == 2) begin
      o.mv = dv; o.ma = da; o.ms = ds; o.md = dw; o.dr = mr;
    end
    return o;
  endfunction

  task automatic tick();
    int n_own, n_last;
    if (!reset_n) begin
      own_rr = 0; last_rr = 1; own_fp = 0; last_fp = 1;
    end else begin
      model_next(1'b1, own_rr, last_rr, i_rr.valid, d_rr.valid, m_rr.ready, n_own, n_last);
      own_rr = n_own; last_rr = n_last;
      model_next(1'b0, own_fp, last_fp, i_fp.valid, d_fp.valid, m_fp.ready, n_own, n_last);
      own_fp = n_own; last_fp = n_last;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic dv,
                       input logic [31:0] da, input logic [3:0] ds, input logic [31:0] dw,
                       input logic [31:0] rd);
    i_rr.valid = iv; i_rr.address = ia; i_rr.wstrobe = 4'h0; i_rr.wdata = 32'h0; i_rr.lookahead = 1'b1;
    i_fp.valid = iv; i_fp.address = ia; i_fp.wstrobe = 4'h0; i_fp.wdata = 32'h0; i_fp.lookahead = 1'b1;
    d_rr.valid = dv; d_rr.address = da; d_rr.wstrobe = ds; d_rr.wdata = dw; d_rr.lookahead = 1'b1;
    d_fp.valid = dv; d_fp.address = da; d_fp.wstrobe = ds; d_fp.wdata = dw; d_fp.lookahead = 1'b1;
    m_rr.rdata = rd;
    m_fp.rdata = rd;
  endtask

  task automatic check_rr(input string tag);
    outs_t e;
    e = model_out(own_rr, i_rr.valid, i_rr.address, d_rr.valid, d_rr.address,
                  d_rr.wstrobe, d_rr.wdata, m_rr.ready);
    chk({tag, " rr.mvalid"}, 32'(m_rr.valid), 32'(e.mv));
    chk({tag, " rr.maddr"}, m_rr.address, e.ma);
    chk({tag, " rr.mwstrobe"}, 32'(m_rr.wstrobe), 32'(e.ms));
    chk({tag, " rr.mwdata"}, m_rr.wdata, e.md);
    chk({tag, " rr.iready"}, 32'(i_rr.ready), 32'(e.ir));
    chk({tag, " rr.dready"}, 32'(d_rr.ready), 32'(e.dr));
    chk({tag, " rr.lookahead"}, 32'(m_rr.lookahead), 32'h0);
    chk({tag, " rr.irdata"}, i_rr.rdata, m_rr.rdata);
    chk({tag, " rr.drdata"}, d_rr.rdata, m_rr.rdata);
  endtask

  task automatic check_fp(input string tag);
    outs_t e;
    e = model_out(own_fp, i_fp.valid, i_fp.address, d_fp.valid, d_fp.address,
                  d_fp.wstrobe, d_fp.wdata, m_fp.ready);
    chk({tag, " fp.mvalid"}, 32'(m_fp.valid), 32'(e.mv));
    chk({tag, " fp.maddr"}, m_fp.address, e.ma);
    chk({tag, " fp.mwstrobe"}, 32'(m_fp.wstrobe), 32'(e.ms));
    chk({tag, " fp.mwdata"}, m_fp.wdata, e.md);
    chk({tag, " fp.iready"}, 32'(i_fp.ready), 32'(e.ir));
    chk({tag, " fp.dready"}, 32'(d_fp.ready), 32'(e.dr));
    chk({tag, " fp.lookahead"}, 32'(m_fp.lookahead), 32'h0);
  endtask

  task automatic check_rr_zero(input string tag);
    chk({tag, " rr.mvalid"}, 32'(m_rr.valid), 32'h0);
    chk({tag, " rr.maddr"}, m_rr.address, 32'h0);
    chk({tag, " rr.mwstrobe"}, 32'(m_rr.wstrobe), 32'h0);
    chk({tag, " rr.mwdata"}, m_rr.wdata, 32'h0);
    chk({tag, " rr.lookahead"}, 32'(m_rr.lookahead), 32'h0);
    chk({tag, " rr.iready"}, 32'(i_rr.ready), 32'h0);
    chk({tag, " rr.dready"}, 32'(d_rr.ready), 32'h0);
  endtask

  task automatic settle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    m_rr.ready = 1'b0;
    m_fp.ready = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, dbad, wbad, mcount, ni, nd, bubbles, repeats, prev, g, fp_i, fp_d, waited;
    logic seen;

    vecs[0]  = '{1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0,
                 '{1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0}};
    vecs[1]  = '{1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0,
                 '{1'b1, 32'h40, 4'h0, 32'h0, 1'b0, 1'b0}};
    vecs[2]  = '{1'b1, 32'h40, 1'b1, 32'h2004, 4'h3, 32'h12345678, 1'b1, 32'hDEADBEEF,
                 '{1'b1, 32'h40, 4'h0, 32'h0, 1'b1, 1'b0}};
    vecs[3]  = '{1'b0, 32'h40, 1'b1, 32'h2004, 4'h3, 32'h12345678, 1'b0, 32'h0,
                 '{1'b1, 32'h2004, 4'h3, 32'h12345678, 1'b0, 1'b0}};
    vecs[4]  = '{1'b0, 32'h40, 1'b1, 32'h2004, 4'h3, 32'h12345678, 1'b1, 32'hCAFE0001,
                 '{1'b1, 32'h2004, 4'h3, 32'h12345678, 1'b0, 1'b1}};
    vecs[5]  = '{1'b1, 32'h80, 1'b1, 32'h3000, 4'hF, 32'hAA, 1'b0, 32'h0,
                 '{1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0}};
    vecs[6]  = '{1'b1, 32'h80, 1'b1, 32'h3000, 4'hF, 32'hAA, 1'b0, 32'h0,
                 '{1'b1, 32'h80, 4'h0, 32'h0, 1'b0, 1'b0}};
    vecs[7]  = '{1'b0, 32'h80, 1'b1, 32'h3000, 4'hF, 32'hAA, 1'b0, 32'h0,
                 '{1'b0, 32'h80, 4'h0, 32'h0, 1'b0, 1'b0}};
    vecs[8]  = '{1'b0, 32'h80, 1'b1, 32'h3000, 4'hF, 32'hAA, 1'b0, 32'h0,
                 '{1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0}};
    vecs[9]  = '{1'b0, 32'h80, 1'b1, 32'h3000, 4'hF, 32'hAA, 1'b1, 32'h55,
                 '{1'b1, 32'h3000, 4'hF, 32'hAA, 1'b0, 1'b1}};
    vecs[10] = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0,
                 '{1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0}};

    // Reset held with both requesters active, then released: data wins first.
    reset_n = 1'b0;
    drive(1'b1, 32'h40, 1'b1, 32'h1000, 4'h5, 32'h99, 32'h0);
    m_rr.ready = 1'b0;
    m_fp.ready = 1'b0;
    tick(); tick(); tick();
    #3;
    check_rr_zero("reset");
    chk("reset fp.mvalid", 32'(m_fp.valid), 32'h0);
    chk("reset fp.dready", 32'(d_fp.ready), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    #3;
    chk("release rr.mvalid", 32'(m_rr.valid), 32'h1);
    chk("release rr.maddr", m_rr.address, 32'h1000);
    chk("release fp.maddr", m_fp.address, 32'h1000);
    check_rr("release");
    tick();
    settle();

    // Directed vector table against the round-robin instance.
    for (int k = 0; k < 11; k++) begin
      drive(vecs[k].iv, vecs[k].ia, vecs[k].dv, vecs[k].da, vecs[k].ds, vecs[k].dw, vecs[k].rd);
      m_rr.ready = vecs[k].mr;
      m_fp.ready = 1'b0;
      #3;
      chk($sformatf("vec%0d mvalid", k), 32'(m_rr.valid), 32'(vecs[k].e.mv));
      chk($sformatf("vec%0d maddr", k), m_rr.address, vecs[k].e.ma);
      chk($sformatf("vec%0d mwstrobe", k), 32'(m_rr.wstrobe), 32'(vecs[k].e.ms));
      chk($sformatf("vec%0d mwdata", k), m_rr.wdata, vecs[k].e.md);
      chk($sformatf("vec%0d iready", k), 32'(i_rr.ready), 32'(vecs[k].e.ir));
      chk($sformatf("vec%0d dready", k), 32'(d_rr.ready), 32'(vecs[k].e.dr));
      chk($sformatf("vec%0d irdata", k), i_rr.rdata, vecs[k].rd);
      chk($sformatf("vec%0d lookahead", k), 32'(m_rr.lookahead), 32'h0);
      tick();
    end
    settle();

    // Single fetch with a two-cycle memory.
    drive(1'b1, 32'h40, 1'b0, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'hDEADBEEF);
    pulses = 0; dbad = 0; wbad = 0; mcount = 0;
    for (int c = 0; c < 8; c++) begin
      m_rr.ready = m_rr.valid && (mcount == 2);
      #3;
      seen = i_rr.ready;
      if (seen) begin
        pulses++;
        chk("fetch irdata", i_rr.rdata, 32'hDEADBEEF);
      end
      if (d_rr.ready) dbad++;
      if (m_rr.wstrobe != 4'h0) wbad++;
      if (m_rr.valid) mcount++;
      tick();
      if (seen) drive(1'b0, 32'h40, 1'b0, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'hDEADBEEF);
    end
    chk("fetch ready pulses", 32'(pulses), 32'd1);
    chk("fetch dready cycles", 32'(dbad), 32'd0);
    chk("fetch wstrobe cycles", 32'(wbad), 32'd0);
    settle();

    // Contention with an always-ready memory.
    drive(1'b1, 32'h100, 1'b1, 32'h200, 4'h1, 32'h7, 32'h0);
    m_rr.ready = 1'b1;
    m_fp.ready = 1'b1;
    tick();
    ni = 0; nd = 0; bubbles = 0; repeats = 0; prev = 0; fp_i = 0; fp_d = 0;
    for (int c = 0; c < 100; c++) begin
      #3;
      g = i_rr.ready ? 1 : (d_rr.ready ? 2 : 0);
      if (g == 0) bubbles++;
      if (g != 0 && g == prev) repeats++;
      if (g == 1) ni++;
      if (g == 2) nd++;
      prev = g;
      if (i_fp.ready) fp_i++;
      if (d_fp.ready) fp_d++;
      tick();
    end
    chk("rr bubbles", 32'(bubbles), 32'd0);
    chk("rr repeats", 32'(repeats), 32'd0);
    chk("rr instr share", 32'(ni), 32'd50);
    chk("rr data share", 32'(nd), 32'd50);
    chk("fp instr grants", 32'(fp_i), 32'd0);
    chk("fp data grants", 32'(fp_d), 32'd100);

    // Data side releases under fixed priority: abort edge, arbitration edge, then I served.
    drive(1'b1, 32'h100, 1'b0, 32'h200, 4'h1, 32'h7, 32'h0);
    waited = -1;
    for (int c = 0; c < 6; c++) begin
      #3;
      check_fp("fp handover");
      if (i_fp.ready && waited < 0) waited = c;
      tick();
    end
    chk("fp handover cycles", 32'(waited), 32'd2);
    settle();

    // Abort: data drops valid mid-grant.
    drive(1'b0, 32'h0, 1'b1, 32'h2004, 4'h3, 32'h12345678, 32'h0);
    tick();
    #3;
    chk("abort granted mvalid", 32'(m_rr.valid), 32'h1);
    d_rr.valid = 1'b0;
    d_fp.valid = 1'b0;
    #1;
    chk("abort same-cycle mvalid", 32'(m_rr.valid), 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h2004, 4'h3, 32'h12345678, 32'h0);
    #3;
    chk("abort idle mvalid", 32'(m_rr.valid), 32'h0);
    check_rr("abort idle");
    tick();
    #3;
    chk("regrant mvalid", 32'(m_rr.valid), 32'h1);
    chk("regrant mwdata", m_rr.wdata, 32'h12345678);

    // Reset mid-grant clears outputs with no clock edge.
    reset_n = 1'b0;
    #1;
    check_rr_zero("async reset");
    tick();
    reset_n = 1'b1;
    settle();

    // Randomized traffic against the reference model, both instances.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 6, $urandom,
            4'($urandom), $urandom, $urandom);
      #1;
      m_rr.ready = m_rr.valid && ($urandom_range(0, 2) != 0);
      m_fp.ready = m_fp.valid && ($urandom_range(0, 2) != 0);
      #2;
      check_rr("random");
      check_fp("random");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
